// File: rtl/rgb_fade_sequencer_if.sv
// Control inputs and duty/status outputs of the RGB fade sequencer.
// The master drives the controls and reads back the duties; the sequencer is the slave.
interface rgb_fade_sequencer_if;
    logic       en;
    logic       pause_tgl;
    logic       next_pulse;
    logic       manual_sel;
    logic [7:0] manual_r;
    logic [7:0] manual_g;
    logic [7:0] manual_b;
    logic [7:0] red_pwm;
    logic [7:0] green_pwm;
    logic [7:0] blue_pwm;
    logic [2:0] color_idx;
    logic [1:0] state;

    modport master (
        output en, pause_tgl, next_pulse, manual_sel, manual_r, manual_g, manual_b,
        input  red_pwm, green_pwm, blue_pwm, color_idx, state
    );

    modport slave (
        input  en, pause_tgl, next_pulse, manual_sel, manual_r, manual_g, manual_b,
        output red_pwm, green_pwm, blue_pwm, color_idx, state
    );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Six-color fade sequencer for the LED PWM duty inputs.
// Ramps one duty unit per tick toward each color, holds, then advances.
module rgb_fade_sequencer #(
    parameter int unsigned TICK_DIV   = 5_000_000,
    parameter int unsigned HOLD_STEPS = 10,
    parameter int unsigned DUTY_MIN   = 1,
    parameter int unsigned DUTY_MAX   = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    rgb_fade_sequencer_if.slave  bus
);

    localparam int unsigned TCW = $clog2(TICK_DIV);
    localparam int unsigned HCW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [7:0]     DMIN      = 8'(DUTY_MIN);
    localparam logic [7:0]     DMAX      = 8'(DUTY_MAX);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    state_t         ret_q, ret_d;
    logic [2:0]     idx_q, idx_d;
    logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]     duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic [7:0]     pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;

    logic [7:0]     tgt_r, tgt_g, tgt_b;
    logic [7:0]     step_r, step_g, step_b;
    logic [2:0]     idx_next;
    logic           running;
    logic           tick;

    function automatic logic [7:0] step_to(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v);
        if (v < DMIN)      return DMIN;
        else if (v > DMAX) return DMAX;
        else               return v;
    endfunction

    always_comb begin
        tgt_r = DMIN;
        tgt_g = DMIN;
        tgt_b = DMIN;
        case (idx_q)
            3'd0:    tgt_r = DMAX;
            3'd1:    begin tgt_r = DMAX; tgt_g = DMAX; end
            3'd2:    tgt_g = DMAX;
            3'd3:    begin tgt_g = DMAX; tgt_b = DMAX; end
            3'd4:    tgt_b = DMAX;
            3'd5:    begin tgt_r = DMAX; tgt_b = DMAX; end
            default: ;
        endcase
    end

    assign step_r   = step_to(duty_r_q, tgt_r);
    assign step_g   = step_to(duty_g_q, tgt_g);
    assign step_b   = step_to(duty_b_q, tgt_b);
    assign idx_next = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    assign running  = ((state_q == RAMP) || (state_q == HOLD)) && !bus.manual_sel;
    assign tick     = running && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ret_q      <= RAMP;
            idx_q      <= '0;
            tick_cnt_q <= '0;
            hold_cnt_q <= '0;
            duty_r_q   <= DMIN;
            duty_g_q   <= DMIN;
            duty_b_q   <= DMIN;
            pwm_r_q    <= DMIN;
            pwm_g_q    <= DMIN;
            pwm_b_q    <= DMIN;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            idx_q      <= idx_d;
            tick_cnt_q <= tick_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            duty_r_q   <= duty_r_d;
            duty_g_q   <= duty_g_d;
            duty_b_q   <= duty_b_d;
            pwm_r_q    <= pwm_r_d;
            pwm_g_q    <= pwm_g_d;
            pwm_b_q    <= pwm_b_d;
        end
    end

    // The tick counter advances (and wraps) even on a pause edge, so a tick
    // coinciding with pause_tgl is consumed without stepping the duties.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        idx_d      = idx_q;
        tick_cnt_d = tick_cnt_q;
        hold_cnt_d = hold_cnt_q;
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;

        if (running) tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);

        if (!bus.en) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
        end else if (!bus.manual_sel) begin
            case (state_q)
                IDLE: begin
                    state_d    = RAMP;
                    tick_cnt_d = '0;
                end
                RAMP, HOLD: begin
                    if (bus.pause_tgl) begin
                        ret_d   = state_q;
                        state_d = PAUSE;
                    end else if (bus.next_pulse) begin
                        idx_d      = idx_next;
                        state_d    = RAMP;
                        tick_cnt_d = '0;
                        hold_cnt_d = '0;
                    end else if (tick) begin
                        if (state_q == RAMP) begin
                            duty_r_d = step_r;
                            duty_g_d = step_g;
                            duty_b_d = step_b;
                            if ((step_r == tgt_r) && (step_g == tgt_g) && (step_b == tgt_b)) begin
                                state_d    = HOLD;
                                hold_cnt_d = '0;
                            end
                        end else if (hold_cnt_q == HOLD_LAST) begin
                            idx_d      = idx_next;
                            state_d    = RAMP;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HCW'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (bus.pause_tgl) state_d = ret_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pwm_r_d = duty_r_q;
        pwm_g_d = duty_g_q;
        pwm_b_d = duty_b_q;
        if (bus.manual_sel) begin
            pwm_r_d = clamp(bus.manual_r);
            pwm_g_d = clamp(bus.manual_g);
            pwm_b_d = clamp(bus.manual_b);
        end
    end

    assign bus.red_pwm   = pwm_r_q;
    assign bus.green_pwm = pwm_g_q;
    assign bus.blue_pwm  = pwm_b_q;
    assign bus.color_idx = idx_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer (TICK_DIV=4, HOLD_STEPS=2).
// Expectations are keyed by clock-edge number; the monitor checks them as the edges occur.
module tb_rgb_fade_sequencer;

    localparam int B = 3;              // edge count at which reset is released
    localparam int ST_IDLE = 0, ST_RAMP = 1, ST_HOLD = 2, ST_PAUSE = 3;

    typedef struct {
        int         at;
        logic [7:0] r, g, b;
        logic [2:0] idx;
        logic [1:0] st;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   edges = 0;
    int   tests = 0;
    int   fails = 0;
    bit   done  = 1'b0;
    exp_t sb[$];
    exp_t e;

    rgb_fade_sequencer_if bus();

    rgb_fade_sequencer #(
        .TICK_DIV  (4),
        .HOLD_STEPS(2),
        .DUTY_MIN  (1),
        .DUTY_MAX  (25)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic expect_at(input int n, input int r, input int g, input int b,
                             input int idx, input int st, input string name);
        exp_t x;
        int   pos;
        x.at = B + n; x.r = 8'(r); x.g = 8'(g); x.b = 8'(b);
        x.idx = 3'(idx); x.st = 2'(st); x.name = name;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > x.at) begin pos = i; break; end
        end
        sb.insert(pos, x);
    endtask

    task automatic wait_to(input int n);
        if (edges > B + n) begin
            $display("FAIL wait_to: edge %0d already passed (now %0d)", B + n, edges);
            $fatal(1);
        end
        while (edges < B + n) @(negedge clk);
    endtask

    // Monitor: compare every expectation due at this edge, shortly after it.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            while (sb.size() > 0 && sb[0].at <= edges) begin
                e = sb.pop_front();
                tests++;
                if (e.at != edges || bus.red_pwm !== e.r || bus.green_pwm !== e.g ||
                    bus.blue_pwm !== e.b || bus.color_idx !== e.idx || bus.state !== e.st) begin
                    fails++;
                    $display("FAIL %s @edge %0d (due %0d): got rgb=(%0d,%0d,%0d) idx=%0d st=%0d, want rgb=(%0d,%0d,%0d) idx=%0d st=%0d",
                             e.name, edges, e.at, bus.red_pwm, bus.green_pwm, bus.blue_pwm,
                             bus.color_idx, bus.state, e.r, e.g, e.b, e.idx, e.st);
                end
            end
            if (done) break;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: never checked, due edge %0d, run ended at %0d", e.name, e.at, edges);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edges);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.en = 1'b0; bus.pause_tgl = 1'b0; bus.next_pulse = 1'b0; bus.manual_sel = 1'b0;
        bus.manual_r = '0; bus.manual_g = '0; bus.manual_b = '0;
        expect_at(0, 1, 1, 1, 0, ST_IDLE, "reset_state");

        // Red ramp, hold, then advance through the whole program and wrap.
        wait_to(0);
        rst = 1'b0; bus.en = 1'b1;
        expect_at(1,   1, 1, 1, 0, ST_RAMP, "idle_to_ramp");
        expect_at(5,   1, 1, 1, 0, ST_RAMP, "first_tick_latency");
        expect_at(6,   2, 1, 1, 0, ST_RAMP, "red_step1");
        expect_at(96,  24, 1, 1, 0, ST_RAMP, "red_24");
        expect_at(97,  24, 1, 1, 0, ST_HOLD, "hold_on_tick24");
        expect_at(98,  25, 1, 1, 0, ST_HOLD, "red_max");
        expect_at(104, 25, 1, 1, 0, ST_HOLD, "hold_end");
        expect_at(105, 25, 1, 1, 1, ST_RAMP, "idx1_ramp");
        expect_at(313, 1, 25, 1, 3, ST_RAMP, "idx3_from_green");
        expect_at(624, 25, 1, 25, 5, ST_HOLD, "magenta_hold");
        expect_at(625, 25, 1, 25, 0, ST_RAMP, "wrap_to_idx0");
        expect_at(630, 25, 1, 24, 0, ST_RAMP, "blue_down1");
        expect_at(721, 25, 1, 2, 0, ST_HOLD, "blue_hold_at_min");
        expect_at(722, 25, 1, 1, 0, ST_HOLD, "red_again");

        // Pause during the yellow ramp with green at 10 (tick counter frozen at 2).
        expect_at(766, 25, 10, 1, 1, ST_RAMP,  "pre_pause");
        expect_at(767, 25, 10, 1, 1, ST_PAUSE, "pause_enter");
        expect_at(867, 25, 10, 1, 1, ST_PAUSE, "pause_100clk");
        expect_at(868, 25, 10, 1, 1, ST_RAMP,  "resume");
        expect_at(870, 25, 10, 1, 1, ST_RAMP,  "resume_tick_edge");
        expect_at(871, 25, 11, 1, 1, ST_RAMP,  "green_11");
        wait_to(766); bus.pause_tgl = 1'b1;
        wait_to(767); bus.pause_tgl = 1'b0;
        wait_to(799); bus.next_pulse = 1'b1;
        wait_to(800); bus.next_pulse = 1'b0;
        wait_to(867); bus.pause_tgl = 1'b1;
        wait_to(868); bus.pause_tgl = 1'b0;

        // Skip from HOLD at idx 2.
        expect_at(1031, 1, 25, 1, 2, ST_HOLD, "green_hold");
        expect_at(1032, 1, 25, 1, 3, ST_RAMP, "next_in_hold");
        expect_at(1036, 1, 25, 1, 3, ST_RAMP, "blue_tick_edge");
        expect_at(1037, 1, 25, 2, 3, ST_RAMP, "blue_step1");
        wait_to(1031); bus.next_pulse = 1'b1;
        wait_to(1032); bus.next_pulse = 1'b0;

        // Manual override with clamping; pause pulse ignored meanwhile.
        expect_at(1038, 1, 25, 13, 3, ST_RAMP, "manual_clamp_a");
        expect_at(1049, 1, 25, 13, 3, ST_RAMP, "manual_held");
        expect_at(1050, 25, 5, 25, 3, ST_RAMP, "manual_clamp_b");
        expect_at(1055, 25, 5, 25, 3, ST_RAMP, "pause_ignored_manual");
        expect_at(1059, 25, 5, 25, 3, ST_RAMP, "manual_last");
        expect_at(1060, 1, 25, 2, 3, ST_RAMP, "manual_release");
        expect_at(1062, 1, 25, 2, 3, ST_RAMP, "resume_tick_edge2");
        expect_at(1063, 1, 25, 3, 3, ST_RAMP, "blue_step2");
        wait_to(1037);
        bus.manual_sel = 1'b1; bus.manual_r = 8'd0; bus.manual_g = 8'd30; bus.manual_b = 8'd13;
        wait_to(1049);
        bus.manual_r = 8'd200; bus.manual_g = 8'd5; bus.manual_b = 8'd26;
        wait_to(1054); bus.pause_tgl = 1'b1;
        wait_to(1055); bus.pause_tgl = 1'b0;
        wait_to(1059); bus.manual_sel = 1'b0;

        // Stop mid-ramp, ignored skip in IDLE, restart, then reset in HOLD.
        expect_at(1067, 1, 25, 4, 3, ST_RAMP, "pre_stop");
        expect_at(1068, 1, 25, 4, 3, ST_IDLE, "en_low_idle");
        expect_at(1080, 1, 25, 4, 3, ST_IDLE, "idle_held");
        expect_at(1081, 1, 25, 4, 3, ST_RAMP, "restart");
        expect_at(1085, 1, 25, 4, 3, ST_RAMP, "restart_tick_edge");
        expect_at(1086, 1, 25, 5, 3, ST_RAMP, "blue_5");
        expect_at(1165, 1, 25, 24, 3, ST_HOLD, "cyan_hold");
        expect_at(1166, 1, 25, 25, 3, ST_HOLD, "cyan_full");
        expect_at(1167, 1, 1, 1, 0, ST_IDLE, "reset_mid_hold");
        expect_at(1168, 1, 1, 1, 0, ST_RAMP, "after_reset_run");
        wait_to(1067); bus.en = 1'b0;
        wait_to(1071); bus.next_pulse = 1'b1;
        wait_to(1072); bus.next_pulse = 1'b0;
        wait_to(1080); bus.en = 1'b1;
        wait_to(1166); rst = 1'b1;
        wait_to(1167); rst = 1'b0;

        wait_to(1170);
        done = 1'b1;
    end

endmodule
